// File: rtl/ldpc_rot_sched.sv
// ldpc_rot_sched
//   Pipelined right-rotate scheduler for the LDPC encoder parity datapath.
//   A request (word + rotation amount) is taken over a valid/ready handshake.
//   The amount is folded modulo WIDTH at the input. It is then applied as SHW
//   power-of-two rotate stages, MSB stage first. The remaining select bits
//   travel alongside the data.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   in_valid/ready  request handshake; in_ready is the global advance enable
//   in_data         word to rotate
//   in_shift        right-rotate amount (values >= WIDTH flag an error)
//   out_valid/ready result handshake; result held stable while stalled
//   out_data        rotated word
//   out_err         the request for this result had in_shift >= WIDTH
//   inflight        number of occupied pipeline stages
//   err_cnt         saturating count of accepted requests with in_shift >= WIDTH
//   err_clr         synchronous clear of err_cnt, wins over an increment
module ldpc_rot_sched #(
   parameter int WIDTH = 360,
   parameter int SHW   = 9,
   parameter int CNTW  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [SHW-1:0]   in_shift,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_err,
   output logic [3:0]       inflight,
   output logic [CNTW-1:0]  err_cnt,
   input  logic             err_clr
);

   localparam logic [SHW-1:0] MODULUS = SHW'(WIDTH);

   logic            adv;
   logic            accept;
   logic            norm_err;
   logic [SHW-1:0]  norm_shift;
   logic [SHW-1:0]  valid_next;
   logic [3:0]      pop_next;
   logic [3:0]      inflight_reg;
   logic [CNTW-1:0] err_cnt_reg;

   // One enable for the whole pipeline. Bubbles travel as valid=0 slots.
   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;
   assign accept   = in_valid && adv;

   // 2^SHW < 2*WIDTH, so a single subtraction is a full modulo.
   assign norm_err   = (in_shift >= MODULUS);
   assign norm_shift = norm_err ? (in_shift - MODULUS) : in_shift;

   // Stage gi holds the word after the rotate for bit gi has been applied. It
   // keeps only the select bits below gi that later stages still need.
   // Stage SHW-1 is fed from the input. Stage 0 is the output register.
   genvar gi;
   generate
      for (gi = 0; gi < SHW; gi++) begin : g_stage
         localparam int ROT = (2 ** gi) % WIDTH;

         logic             valid_q;
         logic             err_q;
         logic [WIDTH-1:0] data_q;
         logic             src_valid;
         logic             src_err;
         logic [WIDTH-1:0] src_data;
         logic [WIDTH-1:0] rot_data;
         logic [gi:0]      src_shift;

         if (gi == SHW-1) begin : g_src_in
            assign src_valid = in_valid;
            assign src_err   = norm_err;
            assign src_data  = in_data;
            assign src_shift = norm_shift;
         end else begin : g_src_prev
            assign src_valid = g_stage[gi+1].valid_q;
            assign src_err   = g_stage[gi+1].err_q;
            assign src_data  = g_stage[gi+1].data_q;
            assign src_shift = g_stage[gi+1].g_sh.shift_q;
         end

         // Right rotate by ROT: out[i] = in[(i+ROT) mod WIDTH].
         assign rot_data = {src_data[ROT-1:0], src_data[WIDTH-1:ROT]};

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               valid_q <= 1'b0;
               err_q   <= 1'b0;
               data_q  <= '0;
            end else if (adv) begin
               valid_q <= src_valid;
               err_q   <= src_err;
               data_q  <= src_shift[gi] ? rot_data : src_data;
            end
         end

         if (gi > 0) begin : g_sh
            logic [gi-1:0] shift_q;
            always_ff @(posedge clk or posedge rst) begin
               if (rst) begin
                  shift_q <= '0;
               end else if (adv) begin
                  shift_q <= src_shift[gi-1:0];
               end
            end
         end

         assign valid_next[gi] = adv ? src_valid : valid_q;
      end
   endgenerate

   assign out_valid = g_stage[0].valid_q;
   assign out_data  = g_stage[0].data_q;
   assign out_err   = g_stage[0].err_q;

   // The registered occupancy is counted from the next-state valid bits. This
   // makes inflight equal to the number of valid stages in the current cycle.
   always_comb begin
      pop_next = 4'd0;
      for (int k = 0; k < SHW; k++) begin
         pop_next = pop_next + {3'b000, valid_next[k]};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inflight_reg <= 4'd0;
      end else begin
         inflight_reg <= pop_next;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_cnt_reg <= '0;
      end else if (err_clr) begin
         err_cnt_reg <= '0;
      end else if (accept && norm_err && (err_cnt_reg != {CNTW{1'b1}})) begin
         err_cnt_reg <= err_cnt_reg + CNTW'(1);
      end
   end

   assign inflight = inflight_reg;
   assign err_cnt  = err_cnt_reg;

endmodule
